// File: rtl/mem_sequencer.sv
// Multi-cycle sequencer sharing one memory port between fetch and load/store.
// Walks FREQ -> EXEC -> (DREQ -> WB) and watchdogs every memory request.
`ifndef W_CPU
`define W_CPU 32
`endif
`ifndef W_MEM_CMD
`define W_MEM_CMD 2
`endif
`ifndef MEM_NOP
`define MEM_NOP 2'b00
`endif
`ifndef MEM_READ
`define MEM_READ 2'b01
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 2'b10
`endif

module mem_sequencer #(
  parameter int W_ADDR  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [W_ADDR-1:0]     fetch_addr,
  output logic [`W_CPU-1:0]     inst,
  output logic                  inst_valid,
  input  logic [`W_MEM_CMD-1:0] dcmd,
  input  logic [W_ADDR-1:0]     daddr,
  input  logic [`W_CPU-1:0]     dwdata,
  output logic [`W_CPU-1:0]     drdata,
  output logic                  commit,
  output logic                  err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [W_ADDR-1:0]     mem_addr,
  output logic [`W_CPU-1:0]     mem_wdata,
  input  logic [`W_CPU-1:0]     mem_rdata,
  input  logic                  mem_ack
);

  typedef enum logic [2:0] {
    FREQ,
    EXEC,
    DREQ,
    WB,
    ERR
  } state_t;

  localparam logic [7:0] TMO =
    (TIMEOUT > 255) ? 8'hFF : TIMEOUT[7:0];

  state_t                state;
  state_t                state_nx;
  logic [`W_CPU-1:0]     inst_q;
  logic [`W_CPU-1:0]     drdata_q;
  logic [`W_CPU-1:0]     wdata_q;
  logic [W_ADDR-1:0]     addr_q;
  logic [`W_MEM_CMD-1:0] cmd_q;
  logic [7:0]            wait_cnt;
  logic                  req_s;
  logic                  tmo;
  logic                  entry;

  // An ack in the limit cycle wins over the timeout.
  assign tmo = (TIMEOUT != 0) && (wait_cnt == TMO) && !mem_ack;

  // Entering a request state restarts the wait counter.
  assign entry = (state_nx != state) &&
                 ((state_nx == FREQ) || (state_nx == DREQ));

  // Reset must pull the request low without waiting for a clock edge.
  assign mem_req    = rst_n & req_s;
  assign inst       = inst_q;
  assign drdata     = drdata_q;
  assign mem_wdata  = wdata_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FREQ;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and Moore outputs; commit in EXEC also looks at dcmd.
  always_comb begin
    state_nx   = state;
    req_s      = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = addr_q;
    commit     = 1'b0;
    inst_valid = 1'b0;
    err        = 1'b0;
    unique case (state)
      FREQ: begin
        req_s    = 1'b1;
        mem_addr = fetch_addr;
        if (mem_ack) begin
          state_nx = EXEC;
        end else if (tmo) begin
          state_nx = ERR;
        end
      end
      EXEC: begin
        inst_valid = 1'b1;
        unique case (dcmd)
          `MEM_NOP: begin
            commit   = 1'b1;
            state_nx = FREQ;
          end
          `MEM_READ,
          `MEM_WRITE: state_nx = DREQ;
          default:    state_nx = ERR;
        endcase
      end
      DREQ: begin
        req_s  = 1'b1;
        mem_we = (cmd_q == `MEM_WRITE);
        if (mem_ack) begin
          state_nx = WB;
        end else if (tmo) begin
          state_nx = ERR;
        end
      end
      WB: begin
        inst_valid = 1'b1;
        commit     = 1'b1;
        state_nx   = FREQ;
      end
      ERR: begin
        err = 1'b1;
      end
      default: begin
        state_nx = ERR;
      end
    endcase
  end

  // Instruction, load data and captured data-access registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q   <= '0;
      drdata_q <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      cmd_q    <= '0;
    end else begin
      if (state == FREQ && mem_ack) begin
        inst_q <= mem_rdata;
      end
      if (state == EXEC &&
          (dcmd == `MEM_READ || dcmd == `MEM_WRITE)) begin
        addr_q  <= daddr;
        wdata_q <= dwdata;
        cmd_q   <= dcmd;
      end
      if (state == DREQ && mem_ack &&
          cmd_q == `MEM_READ) begin
        drdata_q <= mem_rdata;
      end
    end
  end

  // Saturating count of unacked request cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (entry) begin
      wait_cnt <= '0;
    end else if (req_s && !mem_ack && wait_cnt != 8'hFF) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Multi-cycle sequencer sharing one single-port memory between instruction fetch and load/store data access. It sits between the PC/fetch logic, the decoder (whose `mem_cmd` it consumes) and the memory. It runs each instruction through fetch, execute and an optional data access, and emits a one-cycle `commit` pulse that advances the PC and qualifies register write-back. It also watchdogs the memory handshake and latches a sticky error.

## Interface
Parameters:
- `W_ADDR`, default 32: memory address width.
- `TIMEOUT`, default 255: maximum wait cycles per memory request. 0 disables the watchdog.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `fetch_addr`, in, `W_ADDR`: current PC.
- `inst`, out, `` `W_CPU ``: latched instruction; feeds the decoder.
- `inst_valid`, out, 1: `inst` is valid (EXEC and WB states).
- `dcmd`, in, `` `W_MEM_CMD ``: decoder `mem_cmd` (`` `MEM_NOP `` / `` `MEM_READ `` / `` `MEM_WRITE ``).
- `daddr`, in, `W_ADDR`: ALU result, used as the load/store address.
- `dwdata`, in, `` `W_CPU ``: store data (register read port 2).
- `drdata`, out, `` `W_CPU ``: latched load data.
- `commit`, out, 1: one-cycle pulse on instruction completion; PC update and `reg_wen` are gated by it.
- `err`, out, 1: sticky error (timeout or illegal `dcmd`).
- `mem_req`, out, 1: memory request.
- `mem_we`, out, 1: 1 = write, 0 = read.
- `mem_addr`, out, `W_ADDR`: request address.
- `mem_wdata`, out, `` `W_CPU ``: write data.
- `mem_rdata`, in, `` `W_CPU ``: read data; valid in the `mem_ack` cycle.
- `mem_ack`, in, 1: request accepted and completed. May be asserted in the same cycle `mem_req` rises.

## Operation
States: `FREQ`, `EXEC`, `DREQ`, `WB`, `ERR`. All outputs are Moore-decoded from the state and registers, except `commit` in `EXEC`, which also depends on `dcmd`.

- **`FREQ`**
  - Drives `mem_req=1`, `mem_we=0`, `mem_addr=fetch_addr`.
  - On an edge with `mem_ack=1`: `inst<=mem_rdata`, go to `EXEC`.
- **`EXEC`** (`inst_valid=1`, `mem_req=0`). The decoder outputs are settled this cycle.
  - `dcmd==MEM_NOP`: `commit=1`, go to `FREQ`.
  - `dcmd==MEM_READ` or `MEM_WRITE`: capture `daddr`, `dwdata` and the command into internal registers, go to `DREQ`.
  - Any other encoding: go to `ERR`, no commit.
- **`DREQ`**
  - Drives `mem_req=1`, `mem_addr`/`mem_wdata`/`mem_we` from the captured registers.
  - On ack: for a read, `drdata<=mem_rdata`; a write leaves `drdata` unchanged. Go to `WB`.
- **`WB`**: `inst_valid=1`, `commit=1`, `mem_req=0`; next state `FREQ`.
- **`ERR`**: `err=1`, `mem_req=0`, `commit=0`, `inst_valid=0`. Stays in `ERR` until reset.

Handshake rules:
- Address, write enable and write data are held stable while `mem_req=1`.
- `mem_ack` is ignored when `mem_req=0`.
- `mem_req` drops for at least one cycle between requests (`EXEC`/`WB` sit between them).

Watchdog:
- `wait_cnt` (8 bits, saturating) clears on entry to `FREQ`/`DREQ` and increments on each edge with `mem_req=1` and `mem_ack=0`.
- When `TIMEOUT!=0` and `wait_cnt==TIMEOUT` with no ack, go to `ERR`.
- An ack in that same cycle wins over the timeout.

## Timing
- Reset values: state `FREQ`; `inst`, `drdata`, `wait_cnt`, captured registers = 0; `err=0`, `commit=0`, `inst_valid=0`.
- While `rst_n=0`, `mem_req` is forced to 0 asynchronously. The first cycle after reset release asserts `mem_req` with `fetch_addr`.
- Latency with zero-wait memory (ack in the request's first cycle):
  - Non-memory instruction: 2 cycles (`FREQ`, `EXEC`), `commit` in cycle 2.
  - Load/store: 4 cycles (`FREQ`, `EXEC`, `DREQ`, `WB`), `commit` in cycle 4.
  - Each wait cycle adds 1.
- `fetch_addr` must change only after a `commit` edge. It is sampled combinationally throughout `FREQ`.
- `drdata` is valid in `WB` and stays held until the next load's ack.
- Reset asserted mid-request aborts the access with no commit. State returns to the reset values.

## Test plan
- **Reset/first fetch:** hold `rst_n=0` 3 cycles, release with `fetch_addr=0x0040_0000` → `mem_req=1`, `mem_addr=0x0040_0000`, `mem_we=0` in the first cycle; all other outputs at their reset values.
- **NOP path:** zero-wait ack returning `0x2008_0005`, `dcmd=MEM_NOP` → `inst=0x2008_0005`, `inst_valid=1` and a one-cycle `commit` 2 cycles after the request; new fetch follows.
- **Load with waits:** `dcmd=MEM_READ`, `daddr=0x1001_0004`, ack after 3 wait cycles with `mem_rdata=0xDEAD_BEEF` → `mem_we=0` and `mem_addr` stable for all 4 request cycles; `drdata=0xDEAD_BEEF`, `commit` in `WB` only.
- **Store:** `dcmd=MEM_WRITE`, `daddr=0x1001_0008`, `dwdata=0x1234_5678`; change `daddr`/`dwdata` during `DREQ` → memory still sees the captured `0x1001_0008`/`0x1234_5678` with `mem_we=1`; `drdata` unchanged.
- **Timeout:** `TIMEOUT=4`, never ack → `err=1` after 4 unacked cycles, `mem_req=0`, stays latched until `rst_n` pulses low. Repeat with ack landing on the 4th unacked cycle → no error.
- **Illegal command / mid-reset:** `dcmd=2'b11` in `EXEC` → `ERR`, no commit. Separately, assert `rst_n=0` during `DREQ` → `mem_req` drops in the same cycle without waiting for a clock edge, and no commit occurs.
